// File: rtl/ram_port_arbiter.sv
// Byte-serial arbiter sharing one 8-bit RAM/IO port between IF and MEM.
// Multi-byte requests become consecutive byte accesses, read data little-endian.
module ram_port_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_cancel,
    output logic        if_ack,
    output logic [31:0] if_data,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [1:0]  mem_len,
    input  logic [31:0] mem_wdata,
    output logic        mem_ack,
    output logic [31:0] mem_rdata,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_addr,
    output logic        ram_wr,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] base;
    logic [2:0]  len;
    logic [31:0] wdata;
    logic        own_mem;
    logic [2:0]  cnt;
    logic        pend;
    logic [31:0] rbuf;

    logic        grant_if;
    logic        grant;
    logic [2:0]  idx;
    logic        cap;
    logic        last_cap;
    logic        cancel;
    logic [2:0]  mem_n;

    assign grant_if = !mem_req && if_req && !if_cancel;
    assign grant    = rdy && (mem_req || grant_if);
    // pend: an address went out last cycle, its byte is on ram_din now
    assign idx      = cnt + {2'b00, pend};
    assign cap      = (state == RD) && rdy && pend;
    assign last_cap = cap && (cnt + 3'd1 == len);
    assign cancel   = (state == RD) && !own_mem && if_cancel;

    always_comb begin
        unique case (mem_len)
            2'b00:   mem_n = 3'd1;
            2'b01:   mem_n = 3'd2;
            default: mem_n = 3'd4;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (rdy && mem_req)
                    state_nx = mem_we ? WR : RD;
                else if (rdy && grant_if)
                    state_nx = RD;
            end
            RD: begin
                if (cancel)
                    state_nx = IDLE;
                else if (last_cap)
                    state_nx = DONE;
            end
            WR: begin
                if (rdy && cnt == len - 3'd1)
                    state_nx = DONE;
            end
            DONE: begin
                if (rdy)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ram_addr = 32'd0;
        ram_dout = 8'd0;
        ram_wr   = 1'b0;
        unique case (state)
            RD: ram_addr = base + {29'd0, idx};
            WR: begin
                ram_addr = base + {29'd0, cnt};
                ram_dout = wdata[{cnt[1:0], 3'b000} +: 8];
                ram_wr   = rdy;
            end
            default: ;
        endcase
    end

    assign if_ack    = (state == DONE) && rdy && !own_mem;
    assign mem_ack   = (state == DONE) && rdy && own_mem;
    assign if_data   = rbuf;
    assign mem_rdata = rbuf;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            base    <= 32'd0;
            len     <= 3'd0;
            wdata   <= 32'd0;
            own_mem <= 1'b0;
            cnt     <= 3'd0;
            pend    <= 1'b0;
            rbuf    <= 32'd0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        own_mem <= mem_req;
                        base    <= mem_req ? mem_addr : if_addr;
                        len     <= mem_req ? mem_n : 3'd4;
                        wdata   <= mem_wdata;
                        cnt     <= 3'd0;
                        pend    <= 1'b0;
                        rbuf    <= 32'd0;
                    end
                end
                RD: begin
                    // a pause drops the in-flight byte so it gets reissued
                    if (rdy) begin
                        if (pend) begin
                            rbuf[{cnt[1:0], 3'b000} +: 8] <= ram_din;
                            cnt <= cnt + 3'd1;
                        end
                        pend <= (idx < len);
                    end else begin
                        pend <= 1'b0;
                    end
                end
                WR: begin
                    if (rdy)
                        cnt <= cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: transaction-level model with per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_cancel = 1'b0;
    logic        if_ack;
    logic [31:0] if_data;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [1:0]  mem_len = 2'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [7:0]  ram_din = 8'd0;
    logic [7:0]  ram_dout;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic        busy;

    ram_port_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
        .if_ack(if_ack), .if_data(if_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_len(mem_len), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_addr(ram_addr),
        .ram_wr(ram_wr), .busy(busy)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    logic [7:0] ram [bit [31:0]];

    function automatic logic [7:0] rd8(input logic [31:0] a);
        if (ram.exists(a))
            return ram[a];
        return a[7:0] ^ a[31:24] ^ 8'h5A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // RAM returns the byte for last cycle's address
    always @(posedge clk)
        ram_din <= rd8(ram_addr);

    // transaction model
    bit          act = 1'b0;
    bit          m_own;
    bit          m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wd;
    logic [31:0] m_exp;
    int          m_n, age, stall, pauses, got, nw;
    bit          prev_rdy;
    logic [31:0] prev_addr;

    always @(negedge clk) begin
        bit exp_ack;
        bit exp_wr;
        bit mine;
        bit other;
        bit cancel;
        if (rst) begin
            chk("rst_ctl", {28'd0, busy, ram_wr, if_ack, mem_ack}, 32'd0);
            chk("rst_if_data", if_data, 32'd0);
            chk("rst_mem_rdata", mem_rdata, 32'd0);
            chk("rst_ram_addr", ram_addr, 32'd0);
            chk("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
            act = 1'b0;
        end else if (!act) begin
            chk("idle_ctl", {28'd0, busy, ram_wr, if_ack, mem_ack}, 32'd0);
            chk("idle_ram_addr", ram_addr, 32'd0);
            chk("idle_ram_dout", {24'd0, ram_dout}, 32'd0);
            if (rdy && (mem_req || (if_req && !if_cancel))) begin
                m_own  = mem_req;
                m_we   = mem_req && mem_we;
                m_addr = mem_req ? mem_addr : if_addr;
                m_wd   = mem_wdata;
                if (!mem_req)          m_n = 4;
                else if (mem_len == 0) m_n = 1;
                else if (mem_len == 1) m_n = 2;
                else                   m_n = 4;
                m_exp = 32'd0;
                for (int k = 0; k < m_n; k++)
                    m_exp[8*k +: 8] = rd8(m_addr + 32'(k));
                age = 0; stall = 0; pauses = 0; got = 0; nw = 0;
                prev_rdy = 1'b0;
                act = 1'b1;
            end
        end else begin
            age++;
            if (!rdy) stall++;
            if (!rdy && prev_rdy) pauses++;
            chk("busy", {31'd0, busy}, 32'd1);
            exp_ack = rdy && (m_we ? (nw == m_n) : (got == m_n));
            cancel  = !m_own && if_cancel && (got < m_n);
            mine    = m_own ? mem_ack : if_ack;
            other   = m_own ? if_ack : mem_ack;
            chk("ack", {31'd0, mine}, {31'd0, exp_ack});
            chk("other_ack", {31'd0, other}, 32'd0);
            exp_wr = m_we && rdy && (nw < m_n);
            chk("ram_wr", {31'd0, ram_wr}, {31'd0, exp_wr});
            if (ram_wr && exp_wr) begin
                chk("wr_addr", ram_addr, m_addr + 32'(nw));
                chk("wr_byte", {24'd0, ram_dout}, {24'd0, m_wd[8*nw +: 8]});
                ram[ram_addr] = ram_dout;
                nw++;
            end
            if (!m_we && rdy && prev_rdy && got < m_n &&
                prev_addr == m_addr + 32'(got))
                got++;
            prev_rdy  = rdy;
            prev_addr = ram_addr;
            if (cancel) begin
                act = 1'b0;
            end else if (exp_ack) begin
                if (m_we) begin
                    chk("wr_latency", age, m_n + 1 + stall);
                end else begin
                    chk("rd_latency",
                        {31'd0, age >= m_n + 2 + stall &&
                                age <= m_n + 2 + stall + pauses}, 32'd1);
                    if (m_own) chk("mem_rdata", mem_rdata, m_exp);
                    else       chk("if_data", if_data, m_exp);
                end
                act = 1'b0;
            end else if (age > m_n + 3 + stall + pauses) begin
                chk("timeout_age", age, m_n + 3 + stall + pauses);
                act = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic settle();
        if_req = 0; mem_req = 0; if_cancel = 0; rdy = 1;
        repeat (4) tick();
    endtask

    function automatic logic [31:0] pick();
        if ($urandom_range(0, 3) == 0)
            return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        return 32'($urandom_range(0, 63));
    endfunction

    initial begin
        logic [7:0] eb [4];
        int ackc;
        eb = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h00;
        ram[32'h102] = 8'h01; ram[32'h103] = 8'h00;
        ram[32'h200] = 8'h11; ram[32'h201] = 8'hFE;
        ram[32'h202] = 8'h80; ram[32'h203] = 8'h33;
        repeat (2) tick();
        rst = 0;
        settle();

        // IF word read
        tick(); if_req = 1; if_addr = 32'h100; smp();
        for (int c = 1; c <= 6; c++) begin
            tick(); if_req = 0; smp();
            if (c <= 4) chk("t1_addr", ram_addr, 32'h100 + 32'(c - 1));
            if (c == 5) chk("t1_noack", {31'd0, if_ack}, 32'd0);
            if (c == 6) begin
                chk("t1_ack", {31'd0, if_ack}, 32'd1);
                chk("t1_data", if_data, 32'h0001_0013);
            end
        end
        settle();

        // simultaneous requests, MEM byte write wins
        tick();
        mem_req = 1; mem_we = 1; mem_len = 2'b00;
        mem_addr = 32'h30000; mem_wdata = 32'h0000_00A5;
        if_req = 1; if_addr = 32'h100;
        smp();
        for (int c = 1; c <= 9; c++) begin
            tick(); mem_req = 0; if (c >= 4) if_req = 0; smp();
            if (c == 1) begin
                chk("t2_wr", {31'd0, ram_wr}, 32'd1);
                chk("t2_dout", {24'd0, ram_dout}, 32'hA5);
                chk("t2_addr", ram_addr, 32'h30000);
            end
            if (c == 2) begin
                chk("t2_wr_off", {31'd0, ram_wr}, 32'd0);
                chk("t2_mem_ack", {31'd0, mem_ack}, 32'd1);
            end
            if (c == 3) chk("t2_idle", {31'd0, busy}, 32'd0);
            if (c == 8) chk("t2_if_early", {31'd0, if_ack}, 32'd0);
            if (c == 9) chk("t2_if_ack", {31'd0, if_ack}, 32'd1);
        end
        settle();

        // MEM halfword read
        tick();
        mem_req = 1; mem_we = 0; mem_len = 2'b01; mem_addr = 32'h201;
        smp();
        for (int c = 1; c <= 4; c++) begin
            tick(); mem_req = 0; smp();
            if (c == 3) chk("t3_noack", {31'd0, mem_ack}, 32'd0);
            if (c == 4) begin
                chk("t3_ack", {31'd0, mem_ack}, 32'd1);
                chk("t3_rdata", mem_rdata, 32'h0000_80FE);
            end
        end
        settle();

        // MEM word write, len code 10 acts as word
        tick();
        mem_req = 1; mem_we = 1; mem_len = 2'b10;
        mem_addr = 32'h10; mem_wdata = 32'hDEAD_BEEF;
        smp();
        for (int c = 1; c <= 5; c++) begin
            tick(); mem_req = 0; smp();
            if (c <= 4) begin
                chk("t3w_wr", {31'd0, ram_wr}, 32'd1);
                chk("t3w_addr", ram_addr, 32'h10 + 32'(c - 1));
                chk("t3w_byte", {24'd0, ram_dout}, {24'd0, eb[c-1]});
            end
            if (c == 5) chk("t3w_ack", {31'd0, mem_ack}, 32'd1);
        end
        settle();

        // IF read with rdy low in cycles 3..5
        ackc = 0;
        tick(); if_req = 1; if_addr = 32'h100; smp();
        for (int c = 1; c <= 12; c++) begin
            tick(); if_req = 0; rdy = !(c >= 3 && c <= 5); smp();
            if (!rdy) begin
                chk("t4_nowr", {31'd0, ram_wr}, 32'd0);
                chk("t4_noack", {31'd0, if_ack}, 32'd0);
            end
            if (if_ack) begin
                ackc = c;
                chk("t4_data", if_data, 32'h0001_0013);
            end
        end
        chk("t4_ack_cycle", {31'd0, ackc == 9 || ackc == 10}, 32'd1);
        settle();

        // IF read cancelled in cycle 2, new IF read in cycle 3
        tick(); if_req = 1; if_addr = 32'h100; smp();
        for (int c = 1; c <= 9; c++) begin
            tick();
            if_req = (c == 3); if_addr = 32'h200; if_cancel = (c == 2);
            smp();
            if (c == 3) chk("t5_idle", {31'd0, busy}, 32'd0);
            if (c < 9) chk("t5_noack", {31'd0, if_ack}, 32'd0);
            if (c == 9) begin
                chk("t5_ack", {31'd0, if_ack}, 32'd1);
                chk("t5_data", if_data, 32'h3380_FE11);
            end
        end
        settle();

        // reset in cycle 2 of a MEM word write
        tick();
        mem_req = 1; mem_we = 1; mem_len = 2'b11;
        mem_addr = 32'h50; mem_wdata = 32'h1122_3344;
        smp();
        tick(); mem_req = 0; smp();
        chk("t6_wr1", {31'd0, ram_wr}, 32'd1);
        tick(); rst = 1; smp();
        chk("t6_rst_wr", {31'd0, ram_wr}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        tick();
        rst = 0; mem_req = 1; mem_we = 0; mem_len = 2'b00; mem_addr = 32'h50;
        smp();
        for (int c = 1; c <= 3; c++) begin
            tick(); mem_req = 0; smp();
            chk("t6_nowr", {31'd0, ram_wr}, 32'd0);
            if (c == 3) begin
                chk("t6_ack", {31'd0, mem_ack}, 32'd1);
                chk("t6_rdata", mem_rdata, 32'h0000_0044);
            end
        end
        settle();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            tick();
            rdy       = ($urandom_range(0, 7) != 0);
            mem_req   = ($urandom_range(0, 9) < 3);
            mem_we    = 1'($urandom);
            mem_len   = 2'($urandom);
            mem_addr  = pick();
            mem_wdata = $urandom;
            if_req    = ($urandom_range(0, 9) < 4);
            if_addr   = pick();
            if_cancel = ($urandom_range(0, 19) == 0);
        end
        settle();
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Byte-serial arbiter for the single 8-bit RAM/IO port shared by instruction fetch (IF) and the memory stage (MEM). It accepts word, halfword or byte transactions from each requester and sequences them as consecutive byte accesses. It assembles read data little-endian and returns it with a one-cycle acknowledge. It sits between the IF/MEM stages and the top-level `mem_din`/`mem_dout`/`mem_addr`/`mem_wr` pins.

## Interface
- No parameters.
- `clk  in  1`  system clock.
- `rst  in  1`  asynchronous, active-high reset.
- `rdy  in  1`  global ready; low pauses the arbiter.
- `if_req  in  1`  IF read request (always 4 bytes).
- `if_addr  in  32`  IF byte address.
- `if_cancel  in  1`  abort the in-flight IF transaction (branch flush).
- `if_ack  out  1`  one-cycle pulse; `if_data` valid.
- `if_data  out  32`  fetched instruction.
- `mem_req  in  1`  MEM request.
- `mem_we  in  1`  1 = write, 0 = read.
- `mem_addr  in  32`  MEM byte address.
- `mem_len  in  2`  byte count minus 1: 00 = byte, 01 = half, 11 = word (10 is treated as 11).
- `mem_wdata  in  32`  write data; byte i = bits [8i+7:8i].
- `mem_ack  out  1`  one-cycle completion pulse.
- `mem_rdata  out  32`  read data, zero-extended; sign extension is MEM's job.
- `ram_din  in  8`  RAM read byte.
- `ram_dout  out  8`  RAM write byte.
- `ram_addr  out  32`  RAM byte address.
- `ram_wr  out  1`  RAM write strobe.
- `busy  out  1`  high in any state other than IDLE.

## Operation
- States:
  - IDLE
  - RD: issue read addresses, capture returned bytes
  - WR: issue write bytes
  - DONE: ack cycle
- Arbitration happens only in IDLE.
  - If `mem_req` is high, MEM wins.
  - Otherwise, if `if_req` is high, IF is granted.
  - Simultaneous requests: MEM is granted and IF waits.
  - There is no fairness guarantee.
- On grant:
  - The arbiter latches address, length N (1, 2 or 4), write data, direction and owner.
  - Requester inputs are ignored until DONE.
- RD, byte order:
  - Byte k is addressed at `addr+k` for k = 0..N-1.
  - Data for the address driven in cycle c appears on `ram_din` in cycle c+1.
  - Byte k is stored into result bits [8k+7:8k]; unused upper bytes are 0.
- WR: byte k drives `ram_addr=addr+k`, `ram_dout=wdata[8k+7:8k]` and `ram_wr=1` for one cycle each.
- DONE:
  - The owner's ack is high for exactly one cycle with data stable.
  - New requests are not sampled in DONE.
  - The next state is IDLE.
  - A `req` still high in the cycle after ack is a new request.
- `if_cancel`:
  - In RD with owner IF, the arbiter goes to IDLE at the next edge with no `if_ack`.
  - In IDLE, an `if_req` in the same cycle is not granted.
  - It is ignored for MEM transactions. MEM cannot be cancelled.
- Pause (`rdy=0`):
  - FSM, counters and the capture buffer hold.
  - `ram_wr` is forced 0.
  - No byte is captured.
  - On resume, the address whose data was not captured is reissued.
  - The final data is identical to an unpaused transaction.
  - Acks are never issued while `rdy=0`.
- Address arithmetic: 32-bit wrap, with no range checking. IO addresses (`addr[17:16]==2'b11`) are treated the same as RAM addresses.
- Idle outputs: `ram_addr=0`, `ram_dout=0`, `ram_wr=0`.

## Timing
- Cycle 0 is the IDLE cycle in which the winning `req` is high.
- Read of N bytes:
  - `ram_addr=addr+k` in cycle k+1.
  - Last byte is captured at the end of cycle N+1.
  - Ack is high in cycle N+2: byte read → cycle 3, word read → cycle 6.
- Write of N bytes:
  - `ram_wr=1` in cycles 1..N.
  - Ack is high in cycle N+1: byte → cycle 2, word → cycle 5.
- A back-to-back request is granted at the earliest in the cycle after ack (IDLE). Minimum spacing between word reads is 7 cycles.
- Each cycle of `rdy=0` extends latency by 1 cycle, plus at most 1 reissue cycle per pause.
- Reset (asynchronous, including mid-transaction):
  - State goes to IDLE immediately.
  - `ram_wr`, `if_ack`, `mem_ack` and `busy` = 0.
  - `if_data`, `mem_rdata`, `ram_addr` and `ram_dout` = 0.
  - The first request is accepted in the first cycle after `rst` falls.

## Test plan
- IF word read at 0x0000_0100, RAM bytes 13,00,01,00 → `ram_addr` 0x100..0x103 in cycles 1–4, `if_ack` in cycle 6, `if_data=0x0001_0013`.
- `mem_req` and `if_req` high in the same cycle; MEM is a byte write of 0xA5 to 0x30000 → `ram_wr` in cycle 1 only with `ram_dout=0xA5`, `mem_ack` in cycle 2. IF is granted in cycle 3 and `if_ack` arrives in cycle 9.
- MEM halfword read at 0x201, bytes 0xFE,0x80 → `mem_ack` in cycle 4, `mem_rdata=0x0000_80FE`. MEM word write 0xDEADBEEF to 0x10 → bytes EF,BE,AD,DE to 0x10..0x13 in cycles 1–4.
- IF word read with `rdy` low for 3 cycles starting in cycle 3 → no `ram_wr`, data matches the unpaused result, `if_ack` arrives in cycle 9 or 10, and no ack occurs during the pause.
- IF word read, `if_cancel` in cycle 2 → IDLE in cycle 3, `if_ack` never asserted. A new IF request in cycle 3 is granted and produces correct data.
- `rst` asserted in cycle 2 of a MEM word write → `ram_wr`=0 immediately with no further writes and no ack. The request after reset completes normally.
